// File: rtl/cpu_defs.sv
// Shared encodings for the EX stage: ALU, multiply/divide, HI/LO read and forward selects.
package cpu_defs;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_OR   = 3'd2,
    ALU_AND  = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_SLTU = 3'd5,
    ALU_LUI  = 3'd6,
    ALU_XOR  = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    RD_NONE  = 2'd0,
    RD_HI    = 2'd1,
    RD_LO    = 2'd2,
    RD_NONE3 = 2'd3
  } md_rd_e;

  typedef enum logic [1:0] {
    FWD_REG  = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_REG3 = 2'd3
  } fwd_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for the four operations that occupy the unit for several cycles.
  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
module md_unit
  import cpu_defs::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              md_start,
  output logic              md_busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e         state_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] hi_reg, lo_reg;
  logic [DATA_W-1:0] pend_hi_reg, pend_lo_reg;
  logic              pend_wr_reg;

  logic [2*DATA_W-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic                a_neg, b_neg, b_zero;
  logic [DATA_W-1:0]   a_mag, b_mag, b_mag_safe, b_safe;
  logic [DATA_W-1:0]   q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;
  logic [DATA_W-1:0]   res_hi, res_lo;
  logic                res_wr;
  logic [CNT_W-1:0]    res_cycles;

  assign a_sx   = {{DATA_W{op_a[DATA_W-1]}}, op_a};
  assign b_sx   = {{DATA_W{op_b[DATA_W-1]}}, op_b};
  assign a_zx   = {{DATA_W{1'b0}}, op_a};
  assign b_zx   = {{DATA_W{1'b0}}, op_b};
  // Low 2*DATA_W bits of the sign-extended product equal the signed product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed division on magnitudes; MIN stays MIN as an unsigned magnitude, so MIN/-1 wraps to MIN.
  assign a_neg      = op_a[DATA_W-1];
  assign b_neg      = op_b[DATA_W-1];
  assign b_zero     = (op_b == '0);
  assign a_mag      = a_neg ? -op_a : op_a;
  assign b_mag      = b_neg ? -op_b : op_b;
  assign b_mag_safe = b_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : b_mag;
  assign b_safe     = b_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : op_b;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign quot_s     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem_s      = a_neg ? -r_mag : r_mag;
  assign quot_u     = op_a / b_safe;
  assign rem_u      = op_a % b_safe;

  always_comb begin
    res_hi     = '0;
    res_lo     = '0;
    res_wr     = 1'b0;
    res_cycles = CNT_W'(MULT_CYCLES);
    case (md_op_e'(md_op))
      MD_MULT:  begin res_hi = prod_s[2*DATA_W-1:DATA_W]; res_lo = prod_s[DATA_W-1:0]; res_wr = 1'b1; end
      MD_MULTU: begin res_hi = prod_u[2*DATA_W-1:DATA_W]; res_lo = prod_u[DATA_W-1:0]; res_wr = 1'b1; end
      MD_DIV:   begin res_hi = rem_s; res_lo = quot_s; res_wr = !b_zero; res_cycles = CNT_W'(DIV_CYCLES); end
      MD_DIVU:  begin res_hi = rem_u; res_lo = quot_u; res_wr = !b_zero; res_cycles = CNT_W'(DIV_CYCLES); end
      default:  ;
    endcase
  end

  assign md_start = !reset && (state_reg == MD_IDLE) && is_md_arith(md_op);
  assign md_busy  = (state_reg == MD_BUSY);
  assign hi       = hi_reg;
  assign lo       = lo_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= MD_IDLE;
      count_reg   <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_wr_reg <= 1'b0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (is_md_arith(md_op)) begin
            pend_hi_reg <= res_hi;
            pend_lo_reg <= res_lo;
            pend_wr_reg <= res_wr;
            count_reg   <= res_cycles;
            state_reg   <= MD_BUSY;
          end else if (md_op == MD_MTHI) begin
            hi_reg <= op_a;
          end else if (md_op == MD_MTLO) begin
            lo_reg <= op_a;
          end
        end
        MD_BUSY: begin
          if (count_reg == CNT_W'(1)) begin
            if (pend_wr_reg) begin
              hi_reg <= pend_hi_reg;
              lo_reg <= pend_lo_reg;
            end
            count_reg <= '0;
            state_reg <= MD_IDLE;
          end else begin
            count_reg <= count_reg - CNT_W'(1);
          end
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// EX stage: operand forwarding, ALU, link path and the HI/LO multiply/divide unit.
module ex_stage_md
  import cpu_defs::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc8_e,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic [1:0]        fwd_rs,
  input  logic [1:0]        fwd_rt,
  input  logic [DATA_W-1:0] alu_out_m,
  input  logic [DATA_W-1:0] wdata_w,
  input  logic [2:0]        alu_op,
  input  logic              alu_src,
  input  logic              link,
  input  logic [2:0]        md_op,
  input  logic [1:0]        md_rd,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] rt_fwd,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] rs_fwd, alu_b, alu_y;

  always_comb begin
    rs_fwd = rs_data;
    case (fwd_e'(fwd_rs))
      FWD_MEM: rs_fwd = alu_out_m;
      FWD_WB:  rs_fwd = wdata_w;
      default: rs_fwd = rs_data;
    endcase
  end

  always_comb begin
    rt_fwd = rt_data;
    case (fwd_e'(fwd_rt))
      FWD_MEM: rt_fwd = alu_out_m;
      FWD_WB:  rt_fwd = wdata_w;
      default: rt_fwd = rt_data;
    endcase
  end

  assign alu_b = alu_src ? imm_ext : rt_fwd;

  always_comb begin
    alu_y = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD:  alu_y = rs_fwd + alu_b;
      ALU_SUB:  alu_y = rs_fwd - alu_b;
      ALU_OR:   alu_y = rs_fwd | alu_b;
      ALU_AND:  alu_y = rs_fwd & alu_b;
      ALU_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(rs_fwd) < $signed(alu_b))};
      ALU_SLTU: alu_y = {{(DATA_W-1){1'b0}}, (rs_fwd < alu_b)};
      ALU_LUI:  alu_y = alu_b << (DATA_W/2);
      ALU_XOR:  alu_y = rs_fwd ^ alu_b;
      default:  alu_y = '0;
    endcase
  end

  // Link wins over HI/LO reads, which win over the ALU.
  always_comb begin
    if (link)                 result = pc8_e;
    else if (md_rd == RD_HI)  result = hi;
    else if (md_rd == RD_LO)  result = lo;
    else                      result = alu_y;
  end

  md_unit #(
    .DATA_W      (DATA_W),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .op_a     (rs_fwd),
    .op_b     (rt_fwd),
    .md_start (md_start),
    .md_busy  (md_busy),
    .hi       (hi),
    .lo       (lo)
  );

  assign md_stall = md_start | md_busy;

endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: directed scenarios plus random traffic against a behavioural model.
module tb_ex_stage_md;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pc8_e, rs_data, rt_data, imm_ext, alu_out_m, wdata_w;
  logic [1:0]   fwd_rs, fwd_rt, md_rd;
  logic [2:0]   alu_op, md_op;
  logic         alu_src, link;
  logic [W-1:0] result, rt_fwd, hi, lo;
  logic         md_start, md_busy, md_stall;

  always #5 clk = ~clk;

  ex_stage_md #(.DATA_W(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .pc8_e(pc8_e), .rs_data(rs_data), .rt_data(rt_data),
    .imm_ext(imm_ext), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .alu_out_m(alu_out_m),
    .wdata_w(wdata_w), .alu_op(alu_op), .alu_src(alu_src), .link(link), .md_op(md_op),
    .md_rd(md_rd), .result(result), .rt_fwd(rt_fwd), .md_start(md_start),
    .md_busy(md_busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: HI/LO plus a countdown and the result waiting to land.
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit           p_wr = 1'b0;
  int           m_left = 0;

  function automatic logic [W-1:0] fwd_val(input logic [1:0] sel, input logic [W-1:0] r,
                                           input logic [W-1:0] m, input logic [W-1:0] w);
    if (sel == 2'd1) return m;
    if (sel == 2'd2) return w;
    return r;
  endfunction

  function automatic logic [W-1:0] alu_model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return W'(a + b);
      3'd1: return W'(a - b);
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return (sa < sb) ? 1 : 0;
      3'd5: return (a < b) ? 1 : 0;
      3'd6: return W'(b * 65536);
      default: return a ^ b;
    endcase
  endfunction

  logic [W-1:0] e_rs, e_rt, e_res;
  bit           e_start, e_busy;

  // Wait to the falling edge and compare every output against the model.
  task automatic settle();
    e_rs    = fwd_val(fwd_rs, rs_data, alu_out_m, wdata_w);
    e_rt    = fwd_val(fwd_rt, rt_data, alu_out_m, wdata_w);
    e_busy  = (m_left != 0);
    e_start = !reset && !e_busy && (md_op >= 3'd1) && (md_op <= 3'd4);
    if (link)              e_res = pc8_e;
    else if (md_rd == 2'd1) e_res = m_hi;
    else if (md_rd == 2'd2) e_res = m_lo;
    else e_res = alu_model(alu_op, e_rs, alu_src ? imm_ext : e_rt);
    @(negedge clk);
    check("result", result, e_res);
    check("rt_fwd", rt_fwd, e_rt);
    check("md_start", md_start, e_start);
    check("md_busy", md_busy, e_busy);
    check("md_stall", md_stall, e_start | e_busy);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  task automatic tick();
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    @(posedge clk);
    sa = longint'($signed(e_rs)); sb = longint'($signed(e_rt));
    ua = longint'(e_rs);          ub = longint'(e_rt);
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (md_op == 3'd1) begin
      q = sa * sb; {p_hi, p_lo} = q; p_wr = 1; m_left = MC;
    end else if (md_op == 3'd2) begin
      uq = ua * ub; {p_hi, p_lo} = uq; p_wr = 1; m_left = MC;
    end else if (md_op == 3'd3) begin
      p_wr = (e_rt != 0); m_left = DC;
      if (p_wr) begin q = sa / sb; r = sa % sb; p_lo = W'(q); p_hi = W'(r); end
    end else if (md_op == 3'd4) begin
      p_wr = (e_rt != 0); m_left = DC;
      if (p_wr) begin uq = ua / ub; ur = ua % ub; p_lo = W'(uq); p_hi = W'(ur); end
    end else if (md_op == 3'd5) begin
      m_hi = e_rs;
    end else if (md_op == 3'd6) begin
      m_lo = e_rs;
    end
    #1;
  endtask

  task automatic clr();
    pc8_e = '0; rs_data = '0; rt_data = '0; imm_ext = '0; alu_out_m = '0; wdata_w = '0;
    fwd_rs = '0; fwd_rt = '0; md_rd = '0; alu_op = '0; md_op = '0; alu_src = 0; link = 0;
  endtask

  task automatic md_issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    clr(); md_op = op; rs_data = a; rt_data = b;
    settle(); check("start_issue", md_start, 1'b1); tick();
    clr();
  endtask

  task automatic run_busy(input int n);
    for (int i = 0; i < n; i++) begin
      settle(); check("busy_run", md_busy, 1'b1); tick();
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clr(); reset = 1; md_op = 3'd1;
    settle(); tick(); settle(); tick();
    check("rst_hi", hi, 0); check("rst_lo", lo, 0);
    check("rst_busy", md_busy, 0); check("rst_start", md_start, 0);
    reset = 0; clr();

    fwd_rs = 1; alu_out_m = 32'h10; rs_data = 32'h99; alu_src = 1; imm_ext = 5;
    settle(); check("fwd_mem_add", result, 32'h15); tick();
    clr(); fwd_rt = 2; wdata_w = 32'hAB; rt_data = 32'h11;
    settle(); check("fwd_wb_rt", rt_fwd, 32'hAB); tick();
    clr(); fwd_rs = 3; rs_data = 32'h40; alu_out_m = 32'h10; alu_src = 1; imm_ext = 1;
    settle(); check("fwd_rs3", result, 32'h41); tick();
    clr(); rs_data = 32'hFFFF_FFFF; rt_data = 1; alu_op = 4;
    settle(); check("slt", result, 1); tick();
    alu_op = 5; settle(); check("sltu", result, 0); tick();
    clr(); alu_op = 6; alu_src = 1; imm_ext = 32'h1234;
    settle(); check("lui", result, 32'h1234_0000); tick();
    clr(); rs_data = 32'h7FFF_FFFF; rt_data = 1;
    settle(); check("add_wrap", result, 32'h8000_0000); tick();

    md_issue(3'd1, -32'sd3, 32'd7);
    run_busy(2);
    md_op = 3'd2; rs_data = 32'h1234; rt_data = 32'h5678;
    settle(); check("multu_ignored_start", md_start, 0); tick(); clr();
    run_busy(2);
    settle(); check("mult_hi", hi, 32'hFFFF_FFFF); check("mult_lo", lo, 32'hFFFF_FFEB);
    check("mult_done", md_busy, 0); tick();

    md_issue(3'd3, -32'sd7, 32'd2); run_busy(DC);
    settle(); check("div_lo", lo, 32'hFFFF_FFFD); check("div_hi", hi, 32'hFFFF_FFFF); tick();
    md_issue(3'd4, 32'd1234, 32'd0); run_busy(DC);
    settle(); check("divu0_lo", lo, 32'hFFFF_FFFD); check("divu0_hi", hi, 32'hFFFF_FFFF); tick();
    md_issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); run_busy(DC);
    settle(); check("divmin_lo", lo, 32'h8000_0000); check("divmin_hi", hi, 0); tick();

    clr(); md_op = 5; rs_data = 32'h55;
    settle(); check("mthi_nostart", md_start, 0); tick();
    clr(); settle(); check("mthi_hi", hi, 32'h55); check("mthi_busy", md_busy, 0); tick();
    md_rd = 1; settle(); check("mfhi", result, 32'h55); tick();
    link = 1; pc8_e = 32'h1008; settle(); check("link_prio", result, 32'h1008); tick();

    md_issue(3'd3, 32'd100, 32'd3);
    settle(); tick();
    reset = 1; settle(); tick(); reset = 0;
    settle(); check("rst_mid_busy", md_busy, 0); check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0); tick();
    md_issue(3'd1, 32'd6, 32'd9); run_busy(MC);
    settle(); check("post_rst_lo", lo, 32'd54); tick();

    for (int i = 0; i < 600; i++) begin
      rs_data = rnd_val(); rt_data = rnd_val(); imm_ext = rnd_val();
      alu_out_m = rnd_val(); wdata_w = rnd_val(); pc8_e = $urandom;
      fwd_rs = 2'($urandom_range(0, 3)); fwd_rt = 2'($urandom_range(0, 3));
      alu_op = 3'($urandom_range(0, 7)); alu_src = 1'($urandom_range(0, 1));
      link = ($urandom_range(0, 7) == 0); md_rd = 2'($urandom_range(0, 3));
      md_op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 59) == 0);
      settle(); tick();
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised next-generation EX stage for the pipelined MIPS core.
- Keeps the RS/RT forwarding muxes, the ALU with immediate select, and the link (PC+8) result path.
- Adds an iterative multiply/divide unit with architectural HI/LO registers.
- Sits between the ID/EX and EX/MEM pipeline registers and exports busy status to the hazard unit. Decoded controls arrive from the stage controller, so no instruction decode happens here.

Parameters:
- DATA_W, 32, datapath width; must be even and ≥ 16.
- MULT_CYCLES, 5, busy cycles for mult/multu; must be ≥ 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc8_e  in  DATA_W  PC+8 of the EX instruction.
- rs_data  in  DATA_W  RS value from ID/EX.
- rt_data  in  DATA_W  RT value from ID/EX.
- imm_ext  in  DATA_W  extended immediate.
- fwd_rs  in  2  RS forward select.
- fwd_rt  in  2  RT forward select.
- alu_out_m  in  DATA_W  MEM-stage forward value.
- wdata_w  in  DATA_W  WB-stage forward value.
- alu_op  in  3  ALU operation.
- alu_src  in  1  0 selects RT, 1 selects imm_ext.
- link  in  1  1 selects pc8_e as the result.
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
- md_rd  in  2  0 none, 1 mfhi, 2 mflo, 3 none.
- result  out  DATA_W  EX result to EX/MEM.
- rt_fwd  out  DATA_W  forwarded RT, used as store data.
- md_start  out  1  an MD operation is accepted this cycle.
- md_busy  out  1  MD unit is iterating.
- md_stall  out  1  md_start | md_busy, consumed by the hazard unit.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous and active-high.
- Reset values: hi=0, lo=0, MD state IDLE, counter 0, md_busy=0. md_start=0 while reset is high.
- Reset asserted mid-operation aborts the operation, clears HI/LO, and returns to IDLE on that edge.
- Forward muxes (combinational):
  - select 0 → register-file value; 1 → alu_out_m; 2 → wdata_w; 3 → register-file value.
  - rt_fwd is the forwarded RT.
  - ALU B input = alu_src ? imm_ext : rt_fwd.
- ALU (combinational, results wrap modulo 2^DATA_W, no overflow trap):
  - 0 add, 1 sub, 2 or, 3 and, 4 slt (signed), 5 sltu, 6 lui (B << DATA_W/2), 7 xor.
  - slt/sltu return the value 1 or 0, zero-extended.
- Result mux priority: link → pc8_e; else md_rd=1 → hi; else md_rd=2 → lo; else the ALU output.
- MD FSM states: IDLE, BUSY.
  - IDLE with md_op in 1..4:
    - md_start=1 combinationally.
    - At the edge: capture both forwarded operands, load the counter with MULT_CYCLES or DIV_CYCLES, go to BUSY.
  - BUSY:
    - md_busy=1; the counter decrements each edge.
    - On the edge where the counter equals 1: write HI/LO, go to IDLE.
  - Timing: an operation started in cycle 0 has md_busy high in cycles 1..N, and new HI/LO are visible in cycle N+1.
  - IDLE with md_op 5/6: hi (resp. lo) ← forwarded RS at the next edge; no busy cycles.
  - Any md_op arriving while BUSY, including on the completing cycle, is ignored. The hazard unit guarantees this never happens through md_stall.
- Arithmetic:
  - mult/multu: {hi,lo} = full 2·DATA_W product, signed or unsigned respectively.
  - div: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - divu: unsigned quotient and remainder.
  - Divisor 0: hi and lo unchanged, but the busy time is still spent.
  - Signed MIN / -1: lo = MIN, hi = 0.
- mfhi/mflo during BUSY return the old register value. The hazard unit stalls them, so this is not functionally relied upon.

Decomposition:
- Shared package (cpu_defs): ALU_OP codes, MD_OP codes, MD_RD codes, FWD select codes, MD state encoding.
- One sub-module, md_unit: FSM, counter, operand capture, HI/LO registers, start/busy outputs.
  - The functional result may be computed at capture with `*`, `/` and `%` and held until the counter expires; a true iterative datapath is optional.

Test Plan:
- Forwarding:
  - fwd_rs=1, alu_out_m=0x10, rs_data=0x99, alu_op=add, alu_src=1, imm_ext=5 → result=0x15.
  - fwd_rt=2, wdata_w=0xAB, rt_data=0x11 → rt_fwd=0xAB.
  - fwd_rs=3 → register-file value used.
- ALU set-less-than: rs=0xFFFFFFFF, rt=1: slt → 1; sltu → 0. lui with imm 0x1234 → 0x12340000. add 0x7FFFFFFF+1 → 0x80000000, no trap.
- Signed multiply: mult with rs=-3, rt=7 →
  - md_start=1 in cycle 0; md_busy=1 in cycles 1..5.
  - Cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - A multu issued in cycle 3 is ignored.
- Divide boundaries: div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. divu by 0 → hi/lo unchanged. div 0x80000000/-1 → lo=0x80000000, hi=0.
- Move and link paths: mthi rs=0x55 → hi=0x55 next cycle, md_busy stays 0. Then md_rd=1 → result=0x55. link=1 together with md_rd=1 → result=pc8_e.
- Reset mid-operation: reset high in cycle 2 of a div → cycle 3: md_busy=0, hi=lo=0. A mult issued in cycle 4 is accepted.
